reg_scoreboard_tagged: RTL and testbench
========================================

# reg_scoreboard_tagged

Parametrised, tag-tracking register status table for an N-wide in-order issue core. It sits beside the issue unit and tracks, per architectural register, a pending write, a pending load and the tag of the youngest in-flight writer. It reports RAW, WAW and load-use hazards per issue slot, with each slot seeing the destinations claimed by all lower-indexed slots in the same cycle. Writebacks clear state only when their tag matches the recorded youngest writer, so stale completions from overwritten producers are ignored; a flush input discards all pending state.

## Interface
- NUM_ISSUE, 2, issue slots; slot 0 is oldest in program order; range 1-4
- NUM_WB, 2, writeback ports per cycle; range 1-4
- NUM_REGS, 32, architectural registers; power of two; register 0 is hardwired zero
- TAG_W, 4, producer tag width
- RW (localparam), $clog2(NUM_REGS), register index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  NUM_ISSUE  slot k issues this cycle (pre-gated by the issue unit)
- issue_we  in  NUM_ISSUE  slot k writes a destination register
- issue_is_load  in  NUM_ISSUE  slot k is a load
- issue_rd  in  NUM_ISSUE*RW  destination of slot k, at bits [k*RW +: RW]
- issue_tag  in  NUM_ISSUE*TAG_W  producer tag of slot k
- issue_rs1, issue_rs2  in  NUM_ISSUE*RW  source registers of slot k
- use_rs1, use_rs2  in  NUM_ISSUE  slot k reads the corresponding source
- wb_valid  in  NUM_WB  writeback port j completes this cycle
- wb_rd  in  NUM_WB*RW  destination of writeback j
- wb_tag  in  NUM_WB*TAG_W  tag of writeback j
- flush  in  1  discard all pending state at the next edge
- raw_hazard, waw_hazard, load_use  out  NUM_ISSUE  per-slot hazards (combinational)
- src1_tag, src2_tag  out  NUM_ISSUE*TAG_W  tag of the pending producer of rs1/rs2; 0 when the source is not busy
- busy_vec, load_pending_vec  out  NUM_REGS  registered state snapshots
- stale_wb_cnt  out  16  count of ignored (tag-mismatch) writebacks; saturates at 16'hFFFF

## Operation
- State per register r: busy[r], load[r], tag[r]. Register 0 is never set.
- Writeback clear: port j clears busy, load and tag of wb_rd only if wb_valid, wb_rd != 0, busy[wb_rd] and tag[wb_rd] == wb_tag. Any other valid writeback with wb_rd != 0 is stale; stale writebacks to rd 0 are not counted.
- Base view V0 = registered state after all matching writeback clears. Two ports clearing the same register behave as one clear.
- View for slot k: Vk = V0 overlaid, in order for i = 0..k-1, with each claim where issue_valid[i], issue_we[i] and issue_rd[i] != 0. A claim sets busy, sets load to issue_is_load[i] and sets tag to issue_tag[i].
- raw_hazard[k] = (use_rs1 and Vk.busy[rs1]) or (use_rs2 and Vk.busy[rs2]).
- load_use[k] = the same test with Vk.busy and Vk.load. load_use implies raw_hazard.
- waw_hazard[k] = issue_we[k] and rd != 0 and Vk.busy[rd].
- srcN_tag[k] = Vk.tag[rsN] when Vk.busy[rsN], otherwise 0.
- Hazard outputs are evaluated regardless of issue_valid[k] (the issue unit gates slots itself). war is not produced.
- Next state = V_NUM_ISSUE with slot NUM_ISSUE-1's claim applied, so the youngest claim on a register wins.
- An issue claim to the same register as a same-cycle matching writeback wins: the register stays busy with the new tag.
- flush = 1: next busy, load and tag are all 0, overriding issue and writeback. stale_wb_cnt still counts that cycle's stale writebacks. Hazard outputs remain combinational from current state.
- stale_wb_cnt adds the number of stale ports this cycle, up to NUM_WB, and saturates.

## Timing
- Hazards and src tags are purely combinational from state and same-cycle issue/wb inputs; zero latency.
- State becomes visible on busy_vec/load_pending_vec one edge after issue/writeback.
- Async reset: busy_vec = 0, load_pending_vec = 0, all tags 0, stale_wb_cnt = 0. All hazard outputs are therefore 0 while in reset unless a same-cycle slot-0 claim feeds a higher slot.
- Deassertion of reset mid-operation: in-flight writebacks afterwards are counted as stale.

## Test plan
- Slot0 issues ld x5 tag 3; next cycle slot0 reads x5 -> raw_hazard[0]=1, load_use[0]=1, src1_tag=3. Writeback x5 tag 3 in a later cycle -> hazards 0 in that same cycle, busy_vec[5]=0 after the edge.
- Same cycle: slot0 add x7 tag 1, slot1 reads x7 -> raw_hazard[1]=1, load_use[1]=0, src1_tag[1]=1, raw_hazard[0]=0.
- x9 issued tag 2 then tag 6; writeback x9 tag 2 -> busy_vec[9] stays 1, tag 6, stale_wb_cnt=1. Writeback tag 6 -> busy_vec[9]=0.
- Slot0 and slot1 both write x4 (tags 1, 2, slot1 is a load) -> waw_hazard[1]=1; after the edge load_pending_vec[4]=1 and tag=2.
- Writes to x0 on issue and writeback -> busy_vec stays 0, no hazard, stale_wb_cnt unchanged.
- Several registers busy, flush with a simultaneous issue to x3 -> busy_vec=0 next cycle. Assert rst mid-run -> all outputs 0 immediately. Drive 65540 stale writebacks -> stale_wb_cnt=16'hFFFF.

Source files
------------

// File: rtl/reg_scoreboard_tagged.sv
// Tag-tracking register status table for an N-wide in-order issue core.
// Tracks busy / pending-load / youngest-writer tag per architectural register,
// reports RAW, WAW and load-use hazards per slot (each slot sees older
// same-cycle claims), and ignores writebacks whose tag no longer matches.
module reg_scoreboard_tagged #(
    parameter int NUM_ISSUE = 2,
    parameter int NUM_WB    = 2,
    parameter int NUM_REGS  = 32,
    parameter int TAG_W     = 4,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_ISSUE-1:0]       issue_valid,
    input  logic [NUM_ISSUE-1:0]       issue_we,
    input  logic [NUM_ISSUE-1:0]       issue_is_load,
    input  logic [NUM_ISSUE*RW-1:0]    issue_rd,
    input  logic [NUM_ISSUE*TAG_W-1:0] issue_tag,
    input  logic [NUM_ISSUE*RW-1:0]    issue_rs1,
    input  logic [NUM_ISSUE*RW-1:0]    issue_rs2,
    input  logic [NUM_ISSUE-1:0]       use_rs1,
    input  logic [NUM_ISSUE-1:0]       use_rs2,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*RW-1:0]       wb_rd,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
    input  logic                       flush,
    output logic [NUM_ISSUE-1:0]       raw_hazard,
    output logic [NUM_ISSUE-1:0]       waw_hazard,
    output logic [NUM_ISSUE-1:0]       load_use,
    output logic [NUM_ISSUE*TAG_W-1:0] src1_tag,
    output logic [NUM_ISSUE*TAG_W-1:0] src2_tag,
    output logic [NUM_REGS-1:0]        busy_vec,
    output logic [NUM_REGS-1:0]        load_pending_vec,
    output logic [15:0]                stale_wb_cnt
);
    localparam int CW = $clog2(NUM_WB + 1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] load_q, load_d;
    logic [TAG_W-1:0]    tag_q [NUM_REGS];
    logic [TAG_W-1:0]    tag_d [NUM_REGS];
    logic [15:0]         cnt_q, cnt_d;

    // Rolling view: registered state, minus matching writebacks, plus older slots' claims.
    logic [NUM_REGS-1:0] v_busy;
    logic [NUM_REGS-1:0] v_load;
    logic [TAG_W-1:0]    v_tag [NUM_REGS];
    logic [CW-1:0]       stale_n;
    logic [16:0]         cnt_sum;

    // Writeback filtering, then per-slot hazard evaluation over the rolling view.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        stale_n    = '0;
        v_busy     = busy_q;
        v_load     = load_q;
        v_tag      = tag_q;
        raw_hazard = '0;
        waw_hazard = '0;
        load_use   = '0;
        src1_tag   = '0;
        src2_tag   = '0;

        // Match is judged against registered state, so two ports hitting one register clear it once.
        for (int j = 0; j < NUM_WB; j++) begin
            if (wb_valid[j] && (wb_rd[j*RW +: RW] != '0)) begin
                if (busy_q[wb_rd[j*RW +: RW]] &&
                    (tag_q[wb_rd[j*RW +: RW]] == wb_tag[j*TAG_W +: TAG_W])) begin
                    v_busy[wb_rd[j*RW +: RW]] = 1'b0;
                    v_load[wb_rd[j*RW +: RW]] = 1'b0;
                    v_tag[wb_rd[j*RW +: RW]]  = '0;
                end else begin
                    stale_n = stale_n + CW'(1);
                end
            end
        end

        for (int k = 0; k < NUM_ISSUE; k++) begin
            raw_hazard[k] = (use_rs1[k] && v_busy[issue_rs1[k*RW +: RW]]) ||
                            (use_rs2[k] && v_busy[issue_rs2[k*RW +: RW]]);
            load_use[k]   = (use_rs1[k] && v_busy[issue_rs1[k*RW +: RW]] && v_load[issue_rs1[k*RW +: RW]]) ||
                            (use_rs2[k] && v_busy[issue_rs2[k*RW +: RW]] && v_load[issue_rs2[k*RW +: RW]]);
            waw_hazard[k] = issue_we[k] && (issue_rd[k*RW +: RW] != '0) && v_busy[issue_rd[k*RW +: RW]];
            if (v_busy[issue_rs1[k*RW +: RW]]) begin
                src1_tag[k*TAG_W +: TAG_W] = v_tag[issue_rs1[k*RW +: RW]];
            end
            if (v_busy[issue_rs2[k*RW +: RW]]) begin
                src2_tag[k*TAG_W +: TAG_W] = v_tag[issue_rs2[k*RW +: RW]];
            end
            // This slot's claim becomes visible to every younger slot and to next state.
            if (issue_valid[k] && issue_we[k] && (issue_rd[k*RW +: RW] != '0)) begin
                v_busy[issue_rd[k*RW +: RW]] = 1'b1;
                v_load[issue_rd[k*RW +: RW]] = issue_is_load[k];
                v_tag[issue_rd[k*RW +: RW]]  = issue_tag[k*TAG_W +: TAG_W];
            end
        end
    end

    // Next state: final view unless flushed; stale counter saturates.
    always_comb begin
        busy_d = v_busy;
        load_d = v_load;
        tag_d  = v_tag;
        if (flush) begin
            busy_d = '0;
            load_d = '0;
            tag_d  = '{default: '0};
        end
        cnt_sum = {1'b0, cnt_q} + 17'(stale_n);
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    // State registers; the tag table is cleared too so src tags read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            busy_q <= '0;
            load_q <= '0;
            cnt_q  <= '0;
            // NOTE: this small tag array is flop-based and must reset; it is not a RAM macro.
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            load_q <= load_d;
            cnt_q  <= cnt_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_q[r] <= tag_d[r];
            end
        end
    end

    assign busy_vec         = busy_q;
    assign load_pending_vec = load_q;
    assign stale_wb_cnt     = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard_tagged.sv
// Self-checking bench for reg_scoreboard_tagged: hand-derived expectations are
// queued when stimulus is driven and popped when the outputs are sampled.
module tb_reg_scoreboard_tagged;
    localparam int NI = 2;
    localparam int NW = 2;
    localparam int NR = 32;
    localparam int TW = 4;
    localparam int RW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI-1:0]     issue_valid, issue_we, issue_is_load, use_rs1, use_rs2;
    logic [NI*RW-1:0]  issue_rd, issue_rs1, issue_rs2;
    logic [NI*TW-1:0]  issue_tag;
    logic [NW-1:0]     wb_valid;
    logic [NW*RW-1:0]  wb_rd;
    logic [NW*TW-1:0]  wb_tag;
    logic              flush;
    logic [NI-1:0]     raw_hazard, waw_hazard, load_use;
    logic [NI*TW-1:0]  src1_tag, src2_tag;
    logic [NR-1:0]     busy_vec, load_pending_vec;
    logic [15:0]       stale_wb_cnt;

    typedef struct packed {
        logic [NI-1:0]    raw;
        logic [NI-1:0]    waw;
        logic [NI-1:0]    lu;
        logic [NI*TW-1:0] s1;
        logic [NI*TW-1:0] s2;
    } comb_t;

    typedef struct packed {
        logic [NR-1:0] busy;
        logic [NR-1:0] ldp;
        logic [15:0]   cnt;
    } state_t;

    comb_t  cq [$];
    state_t sq [$];
    comb_t  exp_c;
    state_t exp_s;
    int     checks = 0;
    int     errors = 0;

    reg_scoreboard_tagged #(
        .NUM_ISSUE(NI), .NUM_WB(NW), .NUM_REGS(NR), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .issue_tag(issue_tag),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .use_rs1(use_rs1), .use_rs2(use_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag),
        .flush(flush),
        .raw_hazard(raw_hazard), .waw_hazard(waw_hazard), .load_use(load_use),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .busy_vec(busy_vec), .load_pending_vec(load_pending_vec),
        .stale_wb_cnt(stale_wb_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic comb_t mk_c(logic [1:0] raw, logic [1:0] waw, logic [1:0] lu,
                                   logic [7:0] s1, logic [7:0] s2);
        return comb_t'({raw, waw, lu, s1, s2});
    endfunction

    function automatic state_t mk_s(logic [31:0] busy, logic [31:0] ldp, logic [15:0] cnt);
        return state_t'({busy, ldp, cnt});
    endfunction

    function automatic comb_t obs_c();
        return comb_t'({raw_hazard, waw_hazard, load_use, src1_tag, src2_tag});
    endfunction

    function automatic state_t obs_s();
        return state_t'({busy_vec, load_pending_vec, stale_wb_cnt});
    endfunction

    task automatic idle();
        issue_valid = '0; issue_we = '0; issue_is_load = '0;
        issue_rd = '0; issue_tag = '0; issue_rs1 = '0; issue_rs2 = '0;
        use_rs1 = '0; use_rs2 = '0;
        wb_valid = '0; wb_rd = '0; wb_tag = '0;
        flush = 1'b0;
    endtask

    task automatic slot(int k, bit v, bit we, bit ld, int rd, int tag,
                        bit u1, int rs1, bit u2, int rs2);
        issue_valid[k] = v; issue_we[k] = we; issue_is_load[k] = ld;
        issue_rd[k*RW +: RW]  = RW'(rd);
        issue_tag[k*TW +: TW] = TW'(tag);
        use_rs1[k] = u1; issue_rs1[k*RW +: RW] = RW'(rs1);
        use_rs2[k] = u2; issue_rs2[k*RW +: RW] = RW'(rs2);
    endtask

    task automatic wb(int j, int rd, int tag);
        wb_valid[j] = 1'b1;
        wb_rd[j*RW +: RW]  = RW'(rd);
        wb_tag[j*TW +: TW] = TW'(tag);
    endtask

    task automatic test_reset();
        idle();
        cq.push_back(mk_c(2'b00, 2'b00, 2'b00, 8'h00, 8'h00));
        sq.push_back(mk_s(32'h0, 32'h0, 16'h0));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL reset_comb: got %h want %h", obs_c(), exp_c); end
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL reset_state: got %h want %h", obs_s(), exp_s); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_load_use();
        // Issue ld x5 tag 3.
        @(negedge clk); idle(); slot(0, 1, 1, 1, 5, 3, 0, 0, 0, 0);
        sq.push_back(mk_s(32'h20, 32'h20, 16'h0));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL ld_issue_state: got %h want %h", obs_s(), exp_s); end
        // Consumer of x5 in slot 0.
        @(negedge clk); idle(); slot(0, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        cq.push_back(mk_c(2'b01, 2'b00, 2'b01, 8'h03, 8'h00));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL ld_use_comb: got %h want %h", obs_c(), exp_c); end
        // Matching writeback in the same cycle as the consumer.
        @(negedge clk); idle(); slot(0, 1, 0, 0, 0, 0, 1, 5, 0, 0); wb(0, 5, 3);
        cq.push_back(mk_c(2'b00, 2'b00, 2'b00, 8'h00, 8'h00));
        sq.push_back(mk_s(32'h0, 32'h0, 16'h0));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL ld_wb_bypass_comb: got %h want %h", obs_c(), exp_c); end
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL ld_wb_state: got %h want %h", obs_s(), exp_s); end
    endtask

    task automatic test_same_cycle_fwd();
        @(negedge clk); idle();
        slot(0, 1, 1, 0, 7, 1, 0, 0, 0, 0);
        slot(1, 1, 0, 0, 0, 0, 1, 7, 0, 0);
        cq.push_back(mk_c(2'b10, 2'b00, 2'b00, 8'h10, 8'h00));
        sq.push_back(mk_s(32'h80, 32'h0, 16'h0));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL fwd_comb: got %h want %h", obs_c(), exp_c); end
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL fwd_state: got %h want %h", obs_s(), exp_s); end
        @(negedge clk); idle(); wb(1, 7, 1);
        sq.push_back(mk_s(32'h0, 32'h0, 16'h0));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL fwd_clear_state: got %h want %h", obs_s(), exp_s); end
    endtask

    task automatic test_stale_tag();
        @(negedge clk); idle(); slot(0, 1, 1, 0, 9, 2, 0, 0, 0, 0);
        @(negedge clk); idle(); slot(0, 1, 1, 0, 9, 6, 0, 0, 0, 0);
        cq.push_back(mk_c(2'b00, 2'b01, 2'b00, 8'h00, 8'h00));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL reissue_waw_comb: got %h want %h", obs_c(), exp_c); end
        // Old producer (tag 2) completes: ignored, counted.
        @(negedge clk); idle(); slot(0, 1, 0, 0, 0, 0, 1, 9, 0, 0); wb(0, 9, 2);
        cq.push_back(mk_c(2'b01, 2'b00, 2'b00, 8'h06, 8'h00));
        sq.push_back(mk_s(32'h200, 32'h0, 16'h1));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL stale_wb_comb: got %h want %h", obs_c(), exp_c); end
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL stale_wb_state: got %h want %h", obs_s(), exp_s); end
        @(negedge clk); idle(); wb(1, 9, 6);
        sq.push_back(mk_s(32'h0, 32'h0, 16'h1));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL young_wb_state: got %h want %h", obs_s(), exp_s); end
    endtask

    task automatic test_waw_same_cycle();
        @(negedge clk); idle();
        slot(0, 1, 1, 0, 4, 1, 0, 0, 0, 0);
        slot(1, 1, 1, 1, 4, 2, 0, 0, 0, 0);
        cq.push_back(mk_c(2'b00, 2'b10, 2'b00, 8'h00, 8'h00));
        sq.push_back(mk_s(32'h10, 32'h10, 16'h1));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL waw_comb: got %h want %h", obs_c(), exp_c); end
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL waw_state: got %h want %h", obs_s(), exp_s); end
        // Younger claim's tag (2) and load flag must have won; read through rs2.
        @(negedge clk); idle(); slot(0, 1, 0, 0, 0, 0, 0, 0, 1, 4);
        cq.push_back(mk_c(2'b01, 2'b00, 2'b01, 8'h00, 8'h02));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL waw_tag_comb: got %h want %h", obs_c(), exp_c); end
        // Port 0 stale (tag 1), port 1 matches (tag 2).
        @(negedge clk); idle(); wb(0, 4, 1); wb(1, 4, 2);
        sq.push_back(mk_s(32'h0, 32'h0, 16'h2));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL waw_clear_state: got %h want %h", obs_s(), exp_s); end
    endtask

    task automatic test_x0();
        @(negedge clk); idle();
        slot(0, 1, 1, 1, 0, 5, 0, 0, 0, 0);
        slot(1, 1, 1, 0, 0, 6, 1, 0, 1, 0);
        wb(0, 0, 0);
        cq.push_back(mk_c(2'b00, 2'b00, 2'b00, 8'h00, 8'h00));
        sq.push_back(mk_s(32'h0, 32'h0, 16'h2));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL x0_comb: got %h want %h", obs_c(), exp_c); end
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL x0_state: got %h want %h", obs_s(), exp_s); end
    endtask

    task automatic test_wb_claim_race();
        @(negedge clk); idle(); slot(0, 1, 1, 0, 10, 5, 0, 0, 0, 0);
        // Matching writeback and a new claim of x10 in the same cycle; slot 1 reads x10.
        @(negedge clk); idle();
        slot(0, 1, 1, 0, 10, 7, 0, 0, 0, 0);
        slot(1, 1, 0, 0, 0, 0, 1, 10, 0, 0);
        wb(0, 10, 5);
        cq.push_back(mk_c(2'b10, 2'b00, 2'b00, 8'h70, 8'h00));
        sq.push_back(mk_s(32'h400, 32'h0, 16'h2));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL race_comb: got %h want %h", obs_c(), exp_c); end
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL race_state: got %h want %h", obs_s(), exp_s); end
        @(negedge clk); idle(); wb(0, 10, 7);
        sq.push_back(mk_s(32'h0, 32'h0, 16'h2));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL race_clear_state: got %h want %h", obs_s(), exp_s); end
    endtask

    task automatic test_flush();
        @(negedge clk); idle();
        slot(0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        slot(1, 1, 1, 1, 2, 2, 0, 0, 0, 0);
        sq.push_back(mk_s(32'h6, 32'h4, 16'h2));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL preflush_state: got %h want %h", obs_s(), exp_s); end
        @(negedge clk); idle();
        flush = 1'b1;
        slot(0, 1, 1, 0, 3, 3, 0, 0, 0, 0);
        slot(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        wb(0, 2, 9);
        cq.push_back(mk_c(2'b10, 2'b00, 2'b00, 8'h10, 8'h00));
        sq.push_back(mk_s(32'h0, 32'h0, 16'h3));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL flush_comb: got %h want %h", obs_c(), exp_c); end
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL flush_state: got %h want %h", obs_s(), exp_s); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); idle(); slot(0, 1, 1, 0, 6, 1, 0, 0, 0, 0);
        sq.push_back(mk_s(32'h40, 32'h0, 16'h3));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL prereset_state: got %h want %h", obs_s(), exp_s); end
        // Assert reset away from the clock edge: state clears without waiting for an edge.
        @(negedge clk); idle(); slot(0, 1, 0, 0, 0, 0, 1, 6, 0, 0); rst = 1'b1;
        cq.push_back(mk_c(2'b00, 2'b00, 2'b00, 8'h00, 8'h00));
        sq.push_back(mk_s(32'h0, 32'h0, 16'h0));
        #1;
        exp_c = cq.pop_front(); checks++;
        if (obs_c() !== exp_c) begin errors++; $display("FAIL async_rst_comb: got %h want %h", obs_c(), exp_c); end
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL async_rst_state: got %h want %h", obs_s(), exp_s); end
        // In-flight producer completes after reset: now stale.
        @(negedge clk); rst = 1'b0; idle(); wb(1, 6, 1);
        sq.push_back(mk_s(32'h0, 32'h0, 16'h1));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL postreset_stale_state: got %h want %h", obs_s(), exp_s); end
    endtask

    task automatic test_saturate();
        // Counter starts at 1; 32766 double-stale cycles bring it to 16'hFFFD.
        for (int i = 0; i < 32766; i++) begin
            @(negedge clk); idle(); wb(0, 1, 0); wb(1, 2, 0);
        end
        sq.push_back(mk_s(32'h0, 32'h0, 16'hFFFD));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL sat_near_state: got %h want %h", obs_s(), exp_s); end
        @(negedge clk); idle(); wb(0, 1, 0);
        sq.push_back(mk_s(32'h0, 32'h0, 16'hFFFE));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL sat_fffe_state: got %h want %h", obs_s(), exp_s); end
        // +2 would overflow: must clamp.
        @(negedge clk); idle(); wb(0, 1, 0); wb(1, 3, 0);
        sq.push_back(mk_s(32'h0, 32'h0, 16'hFFFF));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL sat_clamp_state: got %h want %h", obs_s(), exp_s); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); wb(0, 1, 0); wb(1, 2, 0);
        end
        sq.push_back(mk_s(32'h0, 32'h0, 16'hFFFF));
        @(posedge clk); #1;
        exp_s = sq.pop_front(); checks++;
        if (obs_s() !== exp_s) begin errors++; $display("FAIL sat_hold_state: got %h want %h", obs_s(), exp_s); end
        @(negedge clk); idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_same_cycle_fwd();
        test_stale_tag();
        test_waw_same_cycle();
        test_x0();
        test_wb_claim_race();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
